spi_loader_responder: RTL and testbench

- Serial-load responder (target side) of the external SPI program-load link: spi_clk, spi_mosi, spi_miso pads.
- Deserialises frames from the external loader, issues one Wishbone-style bus write per frame into memory space, and signals completion on spi_miso.
- Sits between the GPIO pad inputs and the internal memory bus arbiter; used in embed mode while the core is held disabled.

---
 rtl/spi_loader_pkg.sv | 16 +
 rtl/spi_loader_sync.sv | 29 ++
 rtl/spi_loader_responder.sv | 148 ++++++++++++++
 tb/tb_spi_loader_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_loader_pkg.sv
// spi_loader_pkg: shared widths, frame constants and FSM state encodings for the SPI loader responder.
package spi_loader_pkg;
  localparam int SPI_ADDR_W = 24;
  localparam int SPI_DATA_W = 16;
  localparam logic START_BIT = 1'b0;
  localparam logic DIR_WRITE = 1'b1;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_DIR   = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_BUS   = 3'd4;
  localparam state_t ST_RDBUS = 3'd5;
  localparam state_t ST_DONE  = 3'd6;
  localparam state_t ST_RDOUT = 3'd7;
endpackage

// File: rtl/spi_loader_sync.sv
// spi_loader_sync: pad synchroniser for spi_clk/spi_mosi with a falling-edge bit event.
module spi_loader_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_spi_clk,
  input  logic i_spi_mosi,
  output logic o_bit_evt,
  output logic o_mosi
);
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic prev_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_q <= '0;
      mosi_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], i_spi_clk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_spi_mosi};
      prev_q <= sclk_q[SYNC_STAGES-1];
    end
  end
  // both chains have equal depth, so mosi is aligned with the detected edge
  assign o_bit_evt = prev_q & ~sclk_q[SYNC_STAGES-1];
  assign o_mosi = mosi_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_loader_responder.sv
// spi_loader_responder: SPI program-load target, one bus write per frame, done flagged on miso.
// Define SPI_LOADER_READ_EN to turn dir=0 frames into bus reads shifted back out on miso.
module spi_loader_responder
  import spi_loader_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int DATA_W = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [DATA_W-1:0] o_wb_dat,
  input  logic [DATA_W-1:0] i_wb_dat,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  output logic              o_err,
  output logic              o_busy
);
  localparam int CNT_W = $clog2(ADDR_W > DATA_W ? ADDR_W : DATA_W);
  logic bit_evt, mosi;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic err_q, err_d;
  logic addr_end, data_end;
`ifdef SPI_LOADER_READ_EN
  localparam state_t RD_NEXT = ST_RDBUS;
  logic dir_q, dir_d;
  logic [DATA_W-1:0] rd_q, rd_d;
`else
  localparam state_t RD_NEXT = ST_DONE;
  logic unused_rd;
  assign unused_rd = ^i_wb_dat;
`endif
  spi_loader_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_spi_clk  (i_spi_clk),
    .i_spi_mosi (i_spi_mosi),
    .o_bit_evt  (bit_evt),
    .o_mosi     (mosi)
  );
  assign addr_end = cnt_q == CNT_W'(ADDR_W - 1);
  assign data_end = cnt_q == CNT_W'(DATA_W - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d = err_q;
`ifdef SPI_LOADER_READ_EN
    dir_d = dir_q;
    rd_d = rd_q;
`endif
    case (state_q)
      ST_IDLE: if (bit_evt && mosi == START_BIT) begin
        state_d = ST_ADDR;
        cnt_d = '0;
      end
      ST_ADDR: if (bit_evt) begin
        addr_d = {mosi, addr_q[ADDR_W-1:1]};
        cnt_d = addr_end ? '0 : cnt_q + 1'b1;
        state_d = addr_end ? ST_DIR : ST_ADDR;
      end
      ST_DIR: if (bit_evt) begin
`ifdef SPI_LOADER_READ_EN
        dir_d = mosi;
`endif
        state_d = (mosi == DIR_WRITE) ? ST_DATA : RD_NEXT;
      end
      ST_DATA: if (bit_evt) begin
        data_d = {mosi, data_q[DATA_W-1:1]};
        cnt_d = data_end ? '0 : cnt_q + 1'b1;
        state_d = data_end ? ST_BUS : ST_DATA;
      end
      ST_BUS: if (i_wb_ack || i_wb_err) begin
        err_d = err_q | i_wb_err;
        state_d = ST_DONE;
      end
`ifdef SPI_LOADER_READ_EN
      ST_RDBUS: if (i_wb_ack || i_wb_err) begin
        err_d = err_q | i_wb_err;
        rd_d = i_wb_err ? '0 : i_wb_dat;
        state_d = ST_DONE;
      end
      ST_DONE: if (bit_evt) begin
        cnt_d = '0;
        state_d = (dir_q == DIR_WRITE) ? ST_IDLE : ST_RDOUT;
      end
      ST_RDOUT: if (bit_evt) begin
        rd_d = rd_q >> 1;
        cnt_d = data_end ? '0 : cnt_q + 1'b1;
        state_d = data_end ? ST_IDLE : ST_RDOUT;
      end
`else
      ST_DONE: if (bit_evt) begin
        cnt_d = '0;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
`ifdef SPI_LOADER_READ_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dir_q <= 1'b0;
      rd_q <= '0;
    end else begin
      dir_q <= dir_d;
      rd_q <= rd_d;
    end
  end
  assign o_spi_miso = (state_q == ST_DONE) ? 1'b0 : (state_q == ST_RDOUT) ? rd_q[0] : 1'b1;
`else
  assign o_spi_miso = state_q != ST_DONE;
`endif
  assign o_wb_cyc = (state_q == ST_BUS) || (state_q == ST_RDBUS);
  assign o_wb_stb = o_wb_cyc;
  assign o_wb_we = state_q == ST_BUS;
  assign o_wb_adr = addr_q;
  assign o_wb_dat = data_q;
  assign o_err = err_q;
  assign o_busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_spi_loader_responder.sv
// tb_spi_loader_responder: directed frames against a bus responder with a write log.
module tb_spi_loader_responder;
  logic clk, rst, spi_clk, mosi, miso;
  logic cyc, stb, we, ack, err, o_err, busy;
  logic [23:0] adr;
  logic [15:0] dat, rdata;
  logic err_mode;
  int ack_dly, wcnt, nchk, nerr;
  logic [40:0] log_q[$];

  spi_loader_responder dut (
    .i_clk(clk), .i_rst(rst), .i_spi_clk(spi_clk), .i_spi_mosi(mosi), .o_spi_miso(miso),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_adr(adr), .o_wb_dat(dat),
    .i_wb_dat(rdata), .i_wb_ack(ack), .i_wb_err(err), .o_err(o_err), .o_busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (ack || err) begin
      ack = 0;
      err = 0;
    end else if (cyc && stb) begin
      if (wcnt >= ack_dly) begin
        ack = 1;
        err = err_mode;
        log_q.push_back({we, adr, dat});
        wcnt = 0;
      end else wcnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    mosi = b;
    spi_clk = 1;
    repeat (4) @(negedge clk);
    spi_clk = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [23:0] a, input logic dir, input logic [15:0] d);
    send_bit(0);
    for (int i = 0; i < 24; i++) send_bit(a[i]);
    send_bit(dir);
    if (dir) for (int i = 0; i < 16; i++) send_bit(d[i]);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && miso; i++) @(negedge clk);
    chk(tag, miso, 0);
  endtask

  task automatic finish_frame(input string tag);
    wait_done(tag);
    send_bit(1);
    chk({tag, "_idle_miso"}, miso, 1);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic chk_wr(input string tag, input logic [23:0] a, input logic [15:0] d);
    chk({tag, "_count"}, log_q.size(), 1);
    if (log_q.size() > 0) chk(tag, log_q.pop_front(), {1'b1, a, d});
  endtask

  task automatic write_frame(input string tag, input logic [23:0] a, input logic [15:0] d);
    send_frame(a, 1, d);
    finish_frame(tag);
    chk_wr(tag, a, d);
  endtask

  initial begin
    logic [15:0] d1;
    nchk = 0; nerr = 0; wcnt = 0; ack_dly = 0;
    rst = 1; spi_clk = 0; mosi = 1; ack = 0; err = 0; err_mode = 0; rdata = 16'h0400;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 1);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    repeat (3) @(negedge clk);

    // single write with exact request and done latency on the final bit
    d1 = 16'h3888;
    send_bit(0);
    for (int i = 0; i < 24; i++) send_bit(d1[0] ^ d1[0] ^ ((24'h800021 >> i) & 1) != 0);
    send_bit(1);
    for (int i = 0; i < 15; i++) send_bit(d1[i]);
    @(negedge clk);
    mosi = d1[15];
    spi_clk = 1;
    repeat (4) @(negedge clk);
    spi_clk = 0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("lat_cyc_early", cyc, 0);
    @(posedge clk);
    #1 chk("lat_cyc", cyc, 1);
    chk("lat_we", we, 1);
    chk("lat_adr", adr, 24'h800021);
    chk("lat_dat", dat, 16'h3888);
    @(posedge clk);
    #1 chk("lat_miso_low", miso, 0);
    chk("lat_cyc_drop", cyc, 0);
    send_bit(1);
    chk("t1_miso_back", miso, 1);
    chk_wr("t1_wr", 24'h800021, 16'h3888);

    for (int i = 0; i < 30; i++) begin
      ack_dly = $urandom_range(0, 5);
      write_frame("b2b", 24'h800000 + 24'(i * 2), 16'h3000 + 16'(i * 16'h0111));
    end
    chk("b2b_err", o_err, 0);

    ack_dly = 1;
    write_frame("e1", 24'h000100, 16'h1111);
    chk("e1_err", o_err, 0);
    err_mode = 1;
    write_frame("e2", 24'h000101, 16'h2222);
    err_mode = 0;
    chk("e2_err", o_err, 1);
    write_frame("e3", 24'h000102, 16'h3333);
    chk("e3_err_sticky", o_err, 1);

    for (int i = 0; i < 100; i++) send_bit(1);
    chk("idle_no_bus", log_q.size(), 0);
    chk("idle_busy", busy, 0);
    chk("idle_miso", miso, 1);
    write_frame("after_idle", 24'h123456, 16'hA5C3);

    // reset while the master is mid-way through data bit 7
    d1 = 16'h1234;
    send_bit(0);
    for (int i = 0; i < 24; i++) send_bit(i == 0);
    send_bit(1);
    for (int i = 0; i < 7; i++) send_bit(d1[i]);
    @(negedge clk);
    mosi = d1[7];
    spi_clk = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    spi_clk = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_miso", miso, 1);
    chk("mid_rst_adr", adr, 0);
    chk("mid_rst_dat", dat, 0);
    chk("mid_rst_err", o_err, 0);
    rst = 0;
    repeat (4) @(negedge clk);
    write_frame("post_rst", 24'h000010, 16'hBEEF);
    chk("post_rst_only", log_q.size(), 0);

`ifdef SPI_LOADER_READ_EN
    send_frame(24'h800023, 0, 16'h0000);
    wait_done("rd_done");
    chk("rd_count", log_q.size(), 1);
    if (log_q.size() > 0) chk("rd_bus", log_q.pop_front() >> 16, {1'b0, 24'h800023});
    for (int k = 0; k < 16; k++) begin
      send_bit(1);
      chk("rd_bit", miso, rdata[k]);
    end
    send_bit(1);
    chk("rd_end_miso", miso, 1);
    chk("rd_end_busy", busy, 0);
`else
    send_frame(24'h800023, 0, 16'h0000);
    finish_frame("rd_nobus");
    chk("rd_no_bus", log_q.size(), 0);
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
